stk_status_display: RTL and testbench

//  Tracks stack occupancy from PUSH/POP strobes and drives three 7-seg digits "St<n>".
//  HEX4 = 'S', HEX5 = 't', HEX6 = occupancy as one hex digit, HEX5DP = full flag.

---
 rtl/stk_status_display_if.sv | 36 +++
 rtl/stk_status_display.sv | 162 ++++++++++++++++
 tb/tb_stk_status_display.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stk_status_display_if.sv
// rtl/stk_status_display_if.sv - stack strobe inputs and status/display outputs bundled as one interface
//
// Purpose : carries the PUSH/POP/CLR_ERR strobes into the status block and the
//           occupancy, flags and 7-segment display values back out.
// Signals : push, pop, clr_err       strobes from the stack-pointer controller
//           sc[3:0]                  occupancy 0..DEPTH
//           full, empty              occupancy flags
//           err, err_ovf             sticky error present / error is overflow
//           hex4, hex5, hex6 [6:0]   segments {g,f,e,d,c,b,a}, active-low
//           hex5dp                   decimal point on HEX5, active-low
// Modports: master drives the strobes; slave (the display block) drives status.

interface stk_status_display_if;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [3:0] sc;
    logic       full;
    logic       empty;
    logic       err;
    logic       err_ovf;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic [6:0] hex6;
    logic       hex5dp;

    modport master (
        output push, pop, clr_err,
        input  sc, full, empty, err, err_ovf, hex4, hex5, hex6, hex5dp
    );

    modport slave (
        input  push, pop, clr_err,
        output sc, full, empty, err, err_ovf, hex4, hex5, hex6, hex5dp
    );
endinterface

// File: rtl/stk_status_display.sv
// rtl/stk_status_display.sv - stack occupancy tracker with sticky over/underflow error and "St<n>" 7-seg display
//
// Purpose : counts occupancy from push/pop strobes, saturating at 0 and DEPTH,
//           latches the most recent overflow/underflow as a sticky error, and
//           drives HEX4='S', HEX5='t', HEX6=occupancy digit or 'o'/'u'.
// Ports   : CLK  rising-edge clock
//           RST  synchronous reset, active-high
//           bus  stk_status_display_if.slave (strobes in, status/segments out)
// Params  : DEPTH      stack capacity, 1..15
//           BLINK_DIV  clock cycles per blink half-period, only used when
//                      STK_ERR_BLINK_EN is defined
// Macro   : STK_ERR_BLINK_EN - blink the whole display while an error is shown.
//           Undefined: error glyphs are steady.

module stk_status_display #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                 CLK,
    input  logic                 RST,
    stk_status_display_if.slave  bus
);

    typedef enum logic [1:0] {ST_NORMAL, ST_ERR_O, ST_ERR_U} state_t;

    localparam logic [3:0] DEPTH_W   = 4'(DEPTH);
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_T     = 7'b0000111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_U     = 7'b1100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    hex_glyph = 7'b1000000;
            4'h1:    hex_glyph = 7'b1111001;
            4'h2:    hex_glyph = 7'b0100100;
            4'h3:    hex_glyph = 7'b0110000;
            4'h4:    hex_glyph = 7'b0011001;
            4'h5:    hex_glyph = 7'b0010010;
            4'h6:    hex_glyph = 7'b0000010;
            4'h7:    hex_glyph = 7'b1111000;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0010000;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b0000011;
            4'hC:    hex_glyph = 7'b1000110;
            4'hD:    hex_glyph = 7'b0100001;
            4'hE:    hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic       ovf_evt, unf_evt;
    logic       blank_d;
    logic [6:0] hex4_q, hex5_q, hex6_q;
    logic [6:0] hex4_d, hex5_d, hex6_d;
    logic       full_q, empty_q, dp_q;

    // Occupancy and error state. Simultaneous push+pop is a no-op at any level.
    always_comb begin
        sc_d    = sc_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (bus.push && !bus.pop) begin
            if (sc_q == DEPTH_W) ovf_evt = 1'b1;
            else                 sc_d    = sc_q + 4'd1;
        end else if (bus.pop && !bus.push) begin
            if (sc_q == 4'd0)    unf_evt = 1'b1;
            else                 sc_d    = sc_q - 4'd1;
        end

        // An event always beats a clear in the same cycle.
        state_d = state_q;
        if (ovf_evt)          state_d = ST_ERR_O;
        else if (unf_evt)     state_d = ST_ERR_U;
        else if (bus.clr_err) state_d = ST_NORMAL;
    end

`ifdef STK_ERR_BLINK_EN
    localparam int         CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_on_q, phase_on_d;

    // Entering an error state (or switching o<->u) restarts the blink in the ON phase.
    always_comb begin
        cnt_d      = cnt_q;
        phase_on_d = phase_on_q;
        if (state_d == ST_NORMAL || state_d != state_q) begin
            cnt_d      = '0;
            phase_on_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d      = '0;
            phase_on_d = !phase_on_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        blank_d = (state_d != ST_NORMAL) && !phase_on_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            phase_on_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            phase_on_q <= phase_on_d;
        end
    end
`else
    always_comb blank_d = 1'b0;
`endif

    // Display values are computed from next state so they register alongside it.
    always_comb begin
        hex4_d = blank_d ? SEG_BLANK : SEG_S;
        hex5_d = blank_d ? SEG_BLANK : SEG_T;
        case (state_d)
            ST_ERR_O: hex6_d = SEG_O;
            ST_ERR_U: hex6_d = SEG_U;
            default:  hex6_d = hex_glyph(sc_d);
        endcase
        if (blank_d) hex6_d = SEG_BLANK;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_NORMAL;
            sc_q    <= 4'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            dp_q    <= 1'b1;
            hex4_q  <= SEG_S;
            hex5_q  <= SEG_T;
            hex6_q  <= hex_glyph(4'd0);
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            full_q  <= (sc_d == DEPTH_W);
            empty_q <= (sc_d == 4'd0);
            dp_q    <= !(sc_d == DEPTH_W) || blank_d;
            hex4_q  <= hex4_d;
            hex5_q  <= hex5_d;
            hex6_q  <= hex6_d;
        end
    end

    assign bus.sc      = sc_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.err     = (state_q != ST_NORMAL);
    assign bus.err_ovf = (state_q == ST_ERR_O);
    assign bus.hex4    = hex4_q;
    assign bus.hex5    = hex5_q;
    assign bus.hex6    = hex6_q;
    assign bus.hex5dp  = dp_q;

endmodule

// File: tb/tb_stk_status_display.sv
// tb/tb_stk_status_display.sv - scoreboard bench for stk_status_display with a queue-based reference model

module tb_stk_status_display;

    localparam int DEPTH = 8;
    localparam int BD    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    stk_status_display_if bus ();

    stk_status_display #(.DEPTH(DEPTH), .BLINK_DIV(BD)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [3:0] sc;
        logic       full, empty, err, ovf, dp;
        logic [6:0] h4, h5, h6;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] gly [16];
    initial begin
        gly[0]  = 7'b1000000; gly[1]  = 7'b1111001; gly[2]  = 7'b0100100; gly[3]  = 7'b0110000;
        gly[4]  = 7'b0011001; gly[5]  = 7'b0010010; gly[6]  = 7'b0000010; gly[7]  = 7'b1111000;
        gly[8]  = 7'b0000000; gly[9]  = 7'b0010000; gly[10] = 7'b0001000; gly[11] = 7'b0000011;
        gly[12] = 7'b1000110; gly[13] = 7'b0100001; gly[14] = 7'b0000110; gly[15] = 7'b0001110;
    end

    // Reference model: plain integer occupancy and an error kind (0 none, 1 overflow, 2 underflow).
    int m_sc    = 0;
    int m_err   = 0;
    int m_entry = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic step(input bit p, input bit o, input bit c, input bit r);
        exp_t e;
        int   evt;
        bit   blank;
        @(posedge clk);
        #1;
        bus.push    = p;
        bus.pop     = o;
        bus.clr_err = c;
        rst         = r;
        e.due = cyc + 1;
        if (r) begin
            m_sc  = 0;
            m_err = 0;
        end else begin
            evt = 0;
            if (p && !o) begin
                if (m_sc == DEPTH) evt = 1; else m_sc = m_sc + 1;
            end
            if (o && !p) begin
                if (m_sc == 0) evt = 2; else m_sc = m_sc - 1;
            end
            if (evt != 0) begin
                if (evt != m_err) m_entry = e.due;
                m_err = evt;
            end else if (c) begin
                m_err = 0;
            end
        end
        blank = 1'b0;
`ifdef STK_ERR_BLINK_EN
        if (m_err != 0 && (((e.due - m_entry) / BD) % 2) == 1) blank = 1'b1;
`endif
        e.sc    = 4'(m_sc);
        e.full  = (m_sc == DEPTH);
        e.empty = (m_sc == 0);
        e.err   = (m_err != 0);
        e.ovf   = (m_err == 1);
        e.dp    = blank ? 1'b1 : !(m_sc == DEPTH);
        e.h4    = blank ? 7'b1111111 : 7'b0010010;
        e.h5    = blank ? 7'b1111111 : 7'b0000111;
        if (blank)           e.h6 = 7'b1111111;
        else if (m_err == 1) e.h6 = 7'b0100011;
        else if (m_err == 2) e.h6 = 7'b1100011;
        else                 e.h6 = gly[m_sc];
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are sampled at the falling edge after their due rising edge.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due != cyc) check("late_entry", e.due, cyc);
            check("sc",     bus.sc,      e.sc);
            check("full",   bus.full,    e.full);
            check("empty",  bus.empty,   e.empty);
            check("err",    bus.err,     e.err);
            if (e.err) check("err_ovf", bus.err_ovf, e.ovf);
            check("hex4",   bus.hex4,    e.h4);
            check("hex5",   bus.hex5,    e.h5);
            check("hex6",   bus.hex6,    e.h6);
            check("hex5dp", bus.hex5dp,  e.dp);
        end
    end

    initial begin
        int r;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;

        // Reset, then 5 pushes
        step(0, 0, 0, 1);
        repeat (5) step(1, 0, 0, 0);
        // Fill to DEPTH, then overflow
        step(0, 0, 0, 1);
        repeat (DEPTH) step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // Underflow then clear
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        // Push+pop at empty and at full
        step(1, 1, 0, 0);
        repeat (DEPTH) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        // Overflow, drain without clearing, then clear+pop at 0 -> underflow wins
        step(1, 0, 0, 0);
        repeat (DEPTH) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        // Overflow held for 100 cycles; also reset during a possible blink phase
        step(0, 0, 0, 1);
        repeat (DEPTH + 1) step(1, 0, 0, 0);
        repeat (100) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            step(r < 48, (r >= 40) && (r < 85), $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        step(0, 0, 0, 0);

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
